// File: rtl/uart_ram_xfer_pkg.sv
// uart_ram_xfer_pkg: shared constants for the UART <-> BRAM transfer sequencer.
// Holds the byte width, the FSM state encoding and the request-type encoding.
package uart_ram_xfer_pkg;

  localparam int BYTE_W = 8;

  // State encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RX_WAIT  = 3'd1;
  localparam logic [2:0] ST_RX_WRITE = 3'd2;
  localparam logic [2:0] ST_TX_READ  = 3'd3;
  localparam logic [2:0] ST_TX_LOAD  = 3'd4;
  localparam logic [2:0] ST_TX_START = 3'd5;
  localparam logic [2:0] ST_TX_WAIT  = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_RX_WAIT  = ST_RX_WAIT,
    S_RX_WRITE = ST_RX_WRITE,
    S_TX_READ  = ST_TX_READ,
    S_TX_LOAD  = ST_TX_LOAD,
    S_TX_START = ST_TX_START,
    S_TX_WAIT  = ST_TX_WAIT,
    S_DONE     = ST_DONE
  } state_e;

  // Request type of the transfer currently being served
  localparam logic REQ_LOAD = 1'b0;
  localparam logic REQ_DUMP = 1'b1;

endpackage

// File: rtl/uart_ram_xfer_ctrl.sv
// uart_ram_xfer_ctrl: arbitrates load (UART RX -> BRAM) and dump (BRAM -> UART TX)
// requests onto a single byte-wide BRAM port and reports per-request completion.
// Optional RX idle timeout on loads: define UART_RAM_XFER_TIMEOUT_EN.
// All outputs are registered; RAM/busy outputs are decoded from the next state so
// they line up with the state they belong to.
module uart_ram_xfer_ctrl
  import uart_ram_xfer_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              CLK,
  input  logic              JOY_SELECT,
  input  logic              write_to_bram_enable,
  input  logic              write_to_uart_enable,
  input  logic [31:0]       write_addr,
  input  logic [3:0]        bytes_to_write,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_wdata,
  input  logic [BYTE_W-1:0] ram_rdata,
  output logic              busy,
  output logic              write_complete,
  output logic              send_complete,
  output logic              xfer_error
);

  state_e              state_q, state_d;
  logic                pend_load_q, pend_load_d;
  logic                pend_dump_q, pend_dump_d;
  logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
  logic [3:0]          load_cnt_q, load_cnt_d;
  logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
  logic [3:0]          dump_cnt_q, dump_cnt_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [BYTE_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                busy_q, busy_d;
  logic                wr_done_q, wr_done_d;
  logic                snd_done_q, snd_done_d;
  logic                to_hit_s;
  logic                unused_addr_hi_s;

  // Only the low ADDR_W address bits address the BRAM.
  assign unused_addr_hi_s = ^write_addr[31:ADDR_W];

  // Request capture, arbitration and transfer sequencing.
  always_comb begin
    state_d     = state_q;
    pend_load_d = pend_load_q;
    pend_dump_d = pend_dump_q;
    load_addr_d = load_addr_q;
    load_cnt_d  = load_cnt_q;
    dump_addr_d = dump_addr_q;
    dump_cnt_d  = dump_cnt_q;
    req_d       = req_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    ram_wdata_d = ram_wdata_q;
    wr_done_d   = 1'b0;
    snd_done_d  = 1'b0;

    // A strobe only captures when nothing of that type is pending yet.
    if (write_to_bram_enable && !pend_load_q) begin
      pend_load_d = 1'b1;
      load_addr_d = write_addr[ADDR_W-1:0];
      load_cnt_d  = bytes_to_write;
    end else begin
      pend_load_d = pend_load_d;
    end
    if (write_to_uart_enable && !pend_dump_q) begin
      pend_dump_d = 1'b1;
      dump_addr_d = write_addr[ADDR_W-1:0];
      dump_cnt_d  = bytes_to_write;
    end else begin
      pend_dump_d = pend_dump_d;
    end

    case (state_q)
      S_IDLE: begin
        // Loads win over dumps; the loser stays pending.
        if (pend_load_q) begin
          pend_load_d = 1'b0;
          req_d       = REQ_LOAD;
          addr_d      = load_addr_q;
          cnt_d       = load_cnt_q;
          state_d     = (load_cnt_q == 4'd0) ? S_DONE : S_RX_WAIT;
        end else if (pend_dump_q) begin
          pend_dump_d = 1'b0;
          req_d       = REQ_DUMP;
          addr_d      = dump_addr_q;
          cnt_d       = dump_cnt_q;
          state_d     = (dump_cnt_q == 4'd0) ? S_DONE : S_TX_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RX_WAIT: begin
        if (rx_valid) begin
          ram_wdata_d = rx_data;
          state_d     = S_RX_WRITE;
        end else if (to_hit_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RX_WAIT;
        end
      end
      S_RX_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? S_DONE : S_RX_WAIT;
      end
      S_TX_READ: begin
        state_d = S_TX_LOAD;
      end
      S_TX_LOAD: begin
        tx_data_d = ram_rdata;
        state_d   = S_TX_START;
      end
      S_TX_START: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = S_TX_WAIT;
        end else begin
          state_d = S_TX_START;
        end
      end
      S_TX_WAIT: begin
        // tx_start_q is high only in the first TX_WAIT cycle, before tx_busy can rise.
        if (!tx_start_q && !tx_busy) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - 4'd1;
          state_d = (cnt_q == 4'd1) ? S_DONE : S_TX_READ;
        end else begin
          state_d = S_TX_WAIT;
        end
      end
      S_DONE: begin
        wr_done_d  = (req_q == REQ_LOAD);
        snd_done_d = (req_q == REQ_DUMP);
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    ram_en_d   = (state_d == S_RX_WRITE) || (state_d == S_TX_READ);
    ram_we_d   = (state_d == S_RX_WRITE);
    ram_addr_d = ram_en_d ? addr_d : '0;
  end

  // State, request bookkeeping and registered outputs.
  always_ff @(posedge CLK or posedge JOY_SELECT) begin
    if (JOY_SELECT) begin
      state_q     <= S_IDLE;
      pend_load_q <= 1'b0;
      pend_dump_q <= 1'b0;
      load_addr_q <= '0;
      load_cnt_q  <= 4'd0;
      dump_addr_q <= '0;
      dump_cnt_q  <= 4'd0;
      req_q       <= REQ_LOAD;
      addr_q      <= '0;
      cnt_q       <= 4'd0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
      wr_done_q   <= 1'b0;
      snd_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_load_q <= pend_load_d;
      pend_dump_q <= pend_dump_d;
      load_addr_q <= load_addr_d;
      load_cnt_q  <= load_cnt_d;
      dump_addr_q <= dump_addr_d;
      dump_cnt_q  <= dump_cnt_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
      wr_done_q   <= wr_done_d;
      snd_done_q  <= snd_done_d;
    end
  end

`ifdef UART_RAM_XFER_TIMEOUT_EN
  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            abort_q, abort_d;
  logic            xfer_error_q, xfer_error_d;

  // to_cnt_q holds the number of cycles since the last byte (or acceptance),
  // so DONE lands TIMEOUT_CYCLES cycles after the last rx_valid.
  assign to_hit_s = (state_q == S_RX_WAIT) && !rx_valid && (to_cnt_q >= TO_LIMIT);

  // Idle counter, abort flag and error qualifier for the completion pulse.
  always_comb begin
    to_cnt_d     = TO_W'(1);
    abort_d      = abort_q;
    xfer_error_d = 1'b0;
    if (((state_q == S_RX_WAIT) && !rx_valid) || (state_q == S_RX_WRITE)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = TO_W'(1);
    end
    if (state_q == S_IDLE) begin
      abort_d = 1'b0;
    end else if (to_hit_s) begin
      abort_d = 1'b1;
    end else begin
      abort_d = abort_q;
    end
    if ((state_q == S_DONE) && (req_q == REQ_LOAD)) begin
      xfer_error_d = abort_q;
    end else begin
      xfer_error_d = 1'b0;
    end
  end

  // Timeout state registers.
  always_ff @(posedge CLK or posedge JOY_SELECT) begin
    if (JOY_SELECT) begin
      to_cnt_q     <= '0;
      abort_q      <= 1'b0;
      xfer_error_q <= 1'b0;
    end else begin
      to_cnt_q     <= to_cnt_d;
      abort_q      <= abort_d;
      xfer_error_q <= xfer_error_d;
    end
  end

  assign xfer_error = xfer_error_q;
`else
  // Without the timeout a load can never abort.
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CYCLES > 0);
  assign to_hit_s             = 1'b0;
  assign xfer_error           = 1'b0;
`endif

  assign tx_data        = tx_data_q;
  assign tx_start       = tx_start_q;
  assign ram_en         = ram_en_q;
  assign ram_we         = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wdata      = ram_wdata_q;
  assign busy           = busy_q;
  assign write_complete = wr_done_q;
  assign send_complete  = snd_done_q;

endmodule

// File: tb/tb_uart_ram_xfer_ctrl.sv
// tb_uart_ram_xfer_ctrl: scoreboard bench for uart_ram_xfer_ctrl.
// Stimulus pushes expected RAM/TX/completion events into a queue; a negedge
// monitor pops and compares every event the DUT presents, including latencies.
module tb_uart_ram_xfer_ctrl;

  localparam int ADDR_W = 10;

  localparam int EV_WR    = 0;
  localparam int EV_RD    = 1;
  localparam int EV_TX    = 2;
  localparam int EV_WDONE = 3;
  localparam int EV_SDONE = 4;

  typedef struct {
    int kind;
    int addr;
    int data;
    int exp_cyc;
  } ev_t;

  logic              CLK;
  logic              JOY_SELECT;
  logic              write_to_bram_enable;
  logic              write_to_uart_enable;
  logic [31:0]       write_addr;
  logic [3:0]        bytes_to_write;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              busy;
  logic              write_complete;
  logic              send_complete;
  logic              xfer_error;

  ev_t  q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   strobe_cyc = 0;
  int   last_rx_cyc = -100;
  int   last_rd_cyc = -100;
  int   last_wr_cyc = -100;
  int   busy_cnt = 0;
  logic mem_init_done = 1'b0;
  logic [7:0] mem [0:1023];

  uart_ram_xfer_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(50)) dut (
    .CLK(CLK), .JOY_SELECT(JOY_SELECT),
    .write_to_bram_enable(write_to_bram_enable), .write_to_uart_enable(write_to_uart_enable),
    .write_addr(write_addr), .bytes_to_write(bytes_to_write),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .write_complete(write_complete), .send_complete(send_complete),
    .xfer_error(xfer_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // BRAM model: one-cycle read latency, preset contents on first clock.
  always @(posedge CLK) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[8] <= 8'h5A;
      mem_init_done <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  // UART TX model: busy for 10 cycles starting the cycle after tx_start.
  always @(posedge CLK or posedge JOY_SELECT) begin
    if (JOY_SELECT) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic push(input int kind, input int addr, input int data, input int exp_cyc);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.exp_cyc = exp_cyc;
    q.push_back(e);
  endtask

  task automatic lat_check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic observe(input int kind, input int addr, input int data);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event got kind=%0d addr=%0h data=%0h required none (cycle %0d)",
               kind, addr, data, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.addr != addr || e.data != data) begin
      failures++;
      $display("FAIL event got kind=%0d addr=%0h data=%0h required kind=%0d addr=%0h data=%0h (cycle %0d)",
               kind, addr, data, e.kind, e.addr, e.data, cyc);
    end
    case (kind)
      EV_WR: begin
        lat_check("rx_to_write", cyc - last_rx_cyc, 1);
        last_wr_cyc = cyc;
      end
      EV_RD: last_rd_cyc = cyc;
      EV_TX: begin
        lat_check("read_to_tx_start", cyc - last_rd_cyc, 3);
        lat_check("tx_start_while_busy", int'(tx_busy), 0);
      end
      default: begin
        if (e.exp_cyc >= 0) lat_check("done_cycle", cyc, e.exp_cyc);
        else if (kind == EV_WDONE) lat_check("write_to_done", cyc - last_wr_cyc, 2);
      end
    endcase
  endtask

  // Monitor: every visible DUT event is checked against the scoreboard.
  always @(negedge CLK) begin
    if (!JOY_SELECT) begin
      if (ram_en) begin
        if (ram_we) observe(EV_WR, int'(ram_addr), int'(ram_wdata));
        else observe(EV_RD, int'(ram_addr), 0);
      end
      if (tx_start) observe(EV_TX, 0, int'(tx_data));
      if (write_complete) observe(EV_WDONE, 0, int'(xfer_error));
      if (send_complete) observe(EV_SDONE, 0, int'(xfer_error));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic strobe(input logic ld, input logic dp, input logic [31:0] a, input logic [3:0] n);
    write_to_bram_enable = ld;
    write_to_uart_enable = dp;
    write_addr = a;
    bytes_to_write = n;
    strobe_cyc = cyc;
    tick(1);
    write_to_bram_enable = 1'b0;
    write_to_uart_enable = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d);
    rx_data = d;
    rx_valid = 1'b1;
    last_rx_cyc = cyc;
    tick(1);
    rx_valid = 1'b0;
    tick(2);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 400) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL %s_timeout got pending_events=%0d busy=%0b required 0 0", name, q.size(), busy);
      q.delete();
    end
    tick(2);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    JOY_SELECT = 1'b1;
    write_to_bram_enable = 1'b0;
    write_to_uart_enable = 1'b0;
    write_addr = 32'd0;
    bytes_to_write = 4'd0;
    rx_data = 8'd0;
    rx_valid = 1'b0;
    tick(3);

    checks++;
    if ({tx_data, tx_start, ram_en, ram_we, ram_addr, ram_wdata, busy,
         write_complete, send_complete, xfer_error} != '0) begin
      failures++;
      $display("FAIL reset_outputs got nonzero (busy=%0b ram_en=%0b tx_start=%0b) required all 0",
               busy, ram_en, tx_start);
    end
    JOY_SELECT = 1'b0;
    tick(2);

    // Load 3 bytes at address 5.
    push(EV_WR, 5, 8'hA1, -1);
    push(EV_WR, 6, 8'hB2, -1);
    push(EV_WR, 7, 8'hC3, -1);
    push(EV_WDONE, 0, 0, -1);
    strobe(1'b1, 1'b0, 32'd5, 4'd3);
    tick(2);
    send_rx(8'hA1);
    send_rx(8'hB2);
    send_rx(8'hC3);
    wait_done("load3");

    // Dump 4 bytes from address 5 (three just loaded plus preset 0x5A).
    push(EV_RD, 5, 0, -1); push(EV_TX, 0, 8'hA1, -1);
    push(EV_RD, 6, 0, -1); push(EV_TX, 0, 8'hB2, -1);
    push(EV_RD, 7, 0, -1); push(EV_TX, 0, 8'hC3, -1);
    push(EV_RD, 8, 0, -1); push(EV_TX, 0, 8'h5A, -1);
    push(EV_SDONE, 0, 0, -1);
    strobe(1'b0, 1'b1, 32'd5, 4'd4);
    wait_done("dump4");

    // Both strobes in one cycle: load runs first, then the dump reads it back.
    push(EV_WR, 30, 8'h11, -1);
    push(EV_WR, 31, 8'h22, -1);
    push(EV_WDONE, 0, 0, -1);
    push(EV_RD, 30, 0, -1); push(EV_TX, 0, 8'h11, -1);
    push(EV_RD, 31, 0, -1); push(EV_TX, 0, 8'h22, -1);
    push(EV_SDONE, 0, 0, -1);
    strobe(1'b1, 1'b1, 32'd30, 4'd2);
    tick(2);
    send_rx(8'h11);
    send_rx(8'h22);
    wait_done("both");

    // Address wrap with truncation; repeat dump strobe during the load is ignored.
    push(EV_WR, 10'h3FF, 8'hE1, -1);
    push(EV_WR, 10'h000, 8'hE2, -1);
    push(EV_WDONE, 0, 0, -1);
    push(EV_RD, 5, 0, -1); push(EV_TX, 0, 8'hA1, -1);
    push(EV_SDONE, 0, 0, -1);
    strobe(1'b1, 1'b0, 32'h0000_FFFF, 4'd2);
    tick(2);
    strobe(1'b0, 1'b1, 32'd5, 4'd1);
    strobe(1'b0, 1'b1, 32'd200, 4'd2);
    send_rx(8'hE1);
    send_rx(8'hE2);
    wait_done("wrap");

    // Count-0 requests: completion only, two cycles after acceptance.
    strobe(1'b1, 1'b0, 32'd12, 4'd0);
    push(EV_WDONE, 0, 0, strobe_cyc + 3);
    wait_done("load0");
    strobe(1'b0, 1'b1, 32'd12, 4'd0);
    push(EV_SDONE, 0, 0, strobe_cyc + 3);
    wait_done("dump0");

    // Reset in the middle of a dump: outputs clear at once, no completion.
    push(EV_RD, 5, 0, -1); push(EV_TX, 0, 8'hA1, -1);
    strobe(1'b0, 1'b1, 32'd5, 4'd3);
    tick(7);
    lat_check("busy_before_reset", int'(busy), 1);
    JOY_SELECT = 1'b1;
    #1;
    checks++;
    if ({tx_data, tx_start, ram_en, ram_we, ram_addr, ram_wdata, busy,
         write_complete, send_complete, xfer_error} != '0) begin
      failures++;
      $display("FAIL async_reset_outputs got busy=%0b tx_data=%0h ram_wdata=%0h required all 0",
               busy, tx_data, ram_wdata);
    end
    lat_check("events_left_at_reset", q.size(), 0);
    tick(3);
    JOY_SELECT = 1'b0;
    tick(3);

    // rx_valid while idle is dropped; then a normal load and dump.
    send_rx(8'h99);
    push(EV_WR, 100, 8'h77, -1);
    push(EV_WDONE, 0, 0, -1);
    strobe(1'b1, 1'b0, 32'd100, 4'd1);
    tick(2);
    send_rx(8'h77);
    wait_done("post_reset_load");
    push(EV_RD, 100, 0, -1); push(EV_TX, 0, 8'h77, -1);
    push(EV_SDONE, 0, 0, -1);
    strobe(1'b0, 1'b1, 32'd100, 4'd1);
    wait_done("post_reset_dump");

`ifdef UART_RAM_XFER_TIMEOUT_EN
    // Timeout: 3-byte load, only one byte arrives.
    push(EV_WR, 40, 8'h3C, -1);
    strobe(1'b1, 1'b0, 32'd40, 4'd3);
    tick(2);
    send_rx(8'h3C);
    push(EV_WDONE, 0, 1, last_rx_cyc + 51);
    wait_done("timeout");
`endif

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
